rr_dispatch4_16bit: RTL
=======================

# rr_dispatch4_16bit

Round-robin dispatcher feeding the 4-lane 16-bit demux path. Accepts a single stream of words on a valid/ready input, steers each accepted word to the next lane in strict order 1→2→3→4→1, and holds it in a one-entry per-lane buffer until that lane's consumer takes it. Drives the lane-select code (`sel`) consumed by the downstream demux and provides registered, handshaked per-lane outputs.

## Interface
- `width`, 16, data word width in bits
- `clk`  input  1  single clock; all state updates on rising edge
- `rst_n`  input  1  reset, synchronous, active-low
- `in_data`  input  width  word offered by upstream
- `in_valid`  input  1  `in_data` is valid this cycle
- `in_ready`  output  1  dispatcher accepts `in_data` this cycle
- `sel`  output  2  current target lane code: 00=lane1, 01=lane2, 10=lane3, 11=lane4 (registered pointer)
- `out1`..`out4`  output  width each  lane buffer contents; forced to 0 when that lane's valid is low
- `out_valid`  output  4  bit i-1 = lane i holds a word
- `out_ready`  input  4  bit i-1 = lane i consumer takes the word this cycle

## Operation
- State: 2-bit pointer `ptr` (drives `sel`), four width-bit data registers, four valid flags.
- `in_ready = !out_valid[ptr] || out_ready[ptr]` (combinational; a full lane draining this cycle may be refilled in the same cycle).
- Accept = `in_valid && in_ready`. On accept: lane `ptr` data ← `in_data`, valid ← 1, `ptr` ← `ptr+1` mod 4 (3 wraps to 0).
- No accept: `ptr` holds. Strict order; never skips a full lane; a full lane at `ptr` stalls input even if other lanes are empty.
- Drain: `out_valid[i] && out_ready[i]` clears lane i valid at the next edge unless the same lane is refilled that cycle, in which case valid stays 1 with the new data.
- `out_ready[i]` while `out_valid[i]=0` is ignored.
- Lane data outputs gated: `outN = valid ? data_reg : 0`, matching demux convention that unselected/empty lanes read zero.
- `in_data` is don't-care when `in_valid=0`; never captured.

## Timing
- Reset (`rst_n=0` at a rising edge): `ptr=0` (`sel=00`), all valids 0, all data registers 0; hence `out1..out4=0`, `out_valid=0000`, `in_ready=1` in the first cycle after reset.
- Reset mid-operation discards all buffered words; no output handshake completes in the reset cycle.
- Latency: word accepted at edge N appears on its lane with `out_valid` high from edge N (visible in cycle after edge N), i.e. 1 cycle.
- Throughput: 1 word/cycle sustained when every targeted lane is empty or draining.
- `sel` changes only on accept edges; stable while stalled.
- No combinational path from `in_valid`/`in_data` to any output; one path `out_ready[ptr]` → `in_ready`.

## Structure
- Shared package: `width` default (16), lane count (4), 2-bit lane-index type, lane-code constants 00/01/10/11.
- One natural sub-module: `lane_buf_16bit` (one-entry buffer: load, data, valid, take, zero-gated output), instantiated four times; top holds pointer, `in_ready` mux, and load decode (one-hot of `ptr` & accept).

## Test plan
- Reset: hold `rst_n=0` two cycles with `in_valid=1` → `out_valid=0000`, `out1..4=0000`, `sel=00`, `in_ready=1` after release.
- Stream 0x1111, 0x2222, 0x3333, 0x4444, 0x5555 back-to-back, `out_ready=1111` → each lane valid for one cycle in order 1,2,3,4,1; `out1` shows 0x1111 then 0x5555; `sel` sequence 00,01,10,11,00,01.
- Backpressure: `out_ready=0000`, offer 5 words → first four captured in lanes 1–4, `in_ready=0` with `sel=00` and 5th word held upstream; raise `out_ready[0]` → 5th word enters lane 1 same cycle, no bubble, `out_valid` stays 1111.
- Non-skip: lanes 2–4 empty, lane 1 full and not ready, `ptr=00` → `in_ready=0` for 10 cycles, no lane changes.
- Reset mid-stream: lanes 1–3 full, `ptr=11`, pulse `rst_n=0` one cycle → all valids 0, outputs 0, `sel=00`; next word 0xABCD lands in lane 1.
- Idle gating: lane 3 drained with `out_ready[2]=1` → `out3` reads 0x0000 next cycle while stale data register is not observable.

Source files
------------

// File: rtl/rr_dispatch4_16bit_pkg.sv
// Shared definitions for the 4-lane round-robin dispatcher: word width,
// lane count, lane-index type and the lane select codes seen by the demux.
package rr_dispatch4_16bit_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int LANES     = 4;

    typedef logic [1:0] lane_idx_t;

    localparam lane_idx_t LANE1 = 2'b00;
    localparam lane_idx_t LANE2 = 2'b01;
    localparam lane_idx_t LANE3 = 2'b10;
    localparam lane_idx_t LANE4 = 2'b11;

    // Next lane in strict rotation; lane 4 wraps back to lane 1.
    function automatic lane_idx_t next_lane(input lane_idx_t cur);
        return lane_idx_t'(cur + 2'd1);
    endfunction

    // One-hot lane strobe for a lane index, qualified by an enable.
    function automatic logic [LANES-1:0] lane_onehot(input lane_idx_t idx, input logic en);
        logic [LANES-1:0] oh;
        oh = '0;
        if (en) begin
            oh[idx] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_dispatch4_16bit_if.sv
// Bus bundle for the dispatcher: upstream valid/ready word stream, lane
// select code, and the four handshaked lane outputs.
interface rr_dispatch4_16bit_if #(
    parameter int width = 16
);
    import rr_dispatch4_16bit_pkg::*;

    logic [width-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    lane_idx_t        sel;
    logic [width-1:0] out1;
    logic [width-1:0] out2;
    logic [width-1:0] out3;
    logic [width-1:0] out4;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;

    // Producer/consumer side (drives the stream and the lane readies).
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, sel, out1, out2, out3, out4, out_valid
    );

    // Dispatcher side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, sel, out1, out2, out3, out4, out_valid
    );

endinterface

// File: rtl/rr_dispatch4_16bit_lane_buf.sv
// One-entry lane buffer: loads a word, holds it until the consumer takes
// it, and presents zero whenever the entry is empty.
module lane_buf_16bit #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [width-1:0] din,
    input  logic             take,
    output logic [width-1:0] dout,
    output logic             vld
);

    logic [width-1:0] data_p0;
    logic             vld_p0;

    // Entry register: a load wins over a same-cycle take so a draining lane can be refilled without a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_p0 <= '0;
            vld_p0  <= 1'b0;
        end else if (load) begin
            data_p0 <= din;
            vld_p0  <= 1'b1;
        end else if (take && vld_p0) begin
            vld_p0  <= 1'b0;
        end
    end

    // Empty entries read zero so stale data never leaks downstream.
    always_comb begin
        dout = vld_p0 ? data_p0 : '0;
        vld  = vld_p0;
    end

endmodule

// File: rtl/rr_dispatch4_16bit.sv
// Round-robin dispatcher: steers each accepted word to lanes 1,2,3,4 in
// strict rotation, stalling on a full lane rather than skipping it.
module rr_dispatch4_16bit
    import rr_dispatch4_16bit_pkg::*;
#(
    parameter int width = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_dispatch4_16bit_if.slave   bus
);

    lane_idx_t        ptr_p0;
    logic             accept;
    logic             ready_c;
    logic [LANES-1:0] load_c;
    logic [LANES-1:0] vld_c;
    logic [width-1:0] dout_c [LANES];

    // Target lane pointer; advances only when a word is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_p0 <= LANE1;
        end else if (accept) begin
            ptr_p0 <= next_lane(ptr_p0);
        end
    end

    // Ready follows only the targeted lane: empty, or draining this cycle.
    always_comb begin
        ready_c = !vld_c[ptr_p0] || bus.out_ready[ptr_p0];
        accept  = bus.in_valid && ready_c;
        load_c  = lane_onehot(ptr_p0, accept);
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_buf_16bit #(
            .width (width)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load_c[i]),
            .din   (bus.in_data),
            .take  (bus.out_ready[i]),
            .dout  (dout_c[i]),
            .vld   (vld_c[i])
        );
    end

    // Output fan-out onto the bus bundle.
    always_comb begin
        bus.in_ready  = ready_c;
        bus.sel       = ptr_p0;
        bus.out_valid = vld_c;
        bus.out1      = dout_c[0];
        bus.out2      = dout_c[1];
        bus.out3      = dout_c[2];
        bus.out4      = dout_c[3];
    end

endmodule
